// File: rtl/core_pkg.sv
// Shared core constants and width helpers used by the fetch path.
package core_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam int          PC_STEP   = 4;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counter must represent the full value DEPTH, hence depth+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one write port, asynchronous read, no reset.
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int W     = 64,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, buffers {instr, pc+4} pairs
// for decode, and flushes to a single-cycle bubble on an ID-stage redirect.
module fetch_queue
    import core_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [XLEN-1:0]              imem_rd,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    input  logic                         stall_D,
    output logic [XLEN-1:0]              instr_D,
    output logic [XLEN-1:0]              pc_plus4_D,
    output logic                         valid_D,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [XLEN-1:0]   pc_f;
    logic [XLEN-1:0]   pc_plus4_f;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2*XLEN-1:0] head;
    logic              redirect;
    logic              pop;
    logic              push;

    assign pc_plus4_f = pc_f + XLEN'(PC_STEP);
    assign imem_addr  = pc_f;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign valid_D  = ~empty;
    assign redirect = redirect_valid & ~stall_D;
    assign pop      = valid_D & ~stall_D;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign push     = ~full | pop;

    fq_storage #(
        .DEPTH (DEPTH),
        .W     (2*XLEN),
        .AW    (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push & ~redirect),
        .waddr (wr_ptr),
        .wdata ({imem_rd, pc_plus4_f}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f   <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            // Flush; the word currently on imem_rd belongs to the wrong path.
            pc_f   <= redirect_pc;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc_f   <= pc_plus4_f;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign instr_D    = valid_D ? head[2*XLEN-1:XLEN] : XLEN'(NOP_INSTR);
    assign pc_plus4_D = valid_D ? head[XLEN-1:0]      : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected decode-side heads.
module tb_fetch_queue;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        stall_D        = 1'b0;
    logic [31:0] instr_D;
    logic [31:0] pc_plus4_D;
    logic        valid_D;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    // Instruction memory model: word i holds i+1.
    assign imem_rd = (imem_addr >> 2) + 32'd1;

    fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_D        (stall_D),
        .instr_D        (instr_D),
        .pc_plus4_D     (pc_plus4_D),
        .valid_D        (valid_D),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_head(input logic [31:0] instr, input logic [31:0] pc4);
        exp_q.push_back({instr, pc4});
    endtask

    // Monitor: every head that decode actually consumes must match the next expectation.
    always @(negedge clk) begin
        if (!rst && valid_D && !stall_D && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_pop: got instr %h pc4 %h expected no consumable head", instr_D, pc_plus4_D);
            end else begin
                mon_e = exp_q.pop_front();
                chk("head_instr", instr_D, mon_e[63:32]);
                chk("head_pc4", pc_plus4_D, mon_e[31:0]);
            end
        end
    end

    initial begin
        #12;
        chk("rst_valid", 32'(valid_D), 32'd0);
        chk("rst_instr", instr_D, 32'h0);
        chk("rst_pc4", pc_plus4_D, 32'h0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_imem_addr", imem_addr, RESET_PC);

        exp_head(32'd1, 32'h04);
        exp_head(32'd2, 32'h08);
        exp_head(32'd17, 32'h44);
        exp_head(32'd18, 32'h48);
        exp_head(32'h4000_0000, 32'h0);

        // Fill under stall, then drain with no bubble.
        step(1);
        rst = 1'b0;
        stall_D = 1'b1;
        step(1);
        chk("fill_count", 32'(count), 32'd1);
        chk("fill_instr", instr_D, 32'd1);
        chk("fill_pc4", pc_plus4_D, 32'h4);
        step(5);
        chk("stall_count", 32'(count), 32'd4);
        chk("stall_full", 32'(full), 32'd1);
        chk("stall_imem_addr", imem_addr, 32'h10);
        chk("stall_head", instr_D, 32'd1);
        stall_D = 1'b0;
        step(1);
        chk("full_pop_count", 32'(count), 32'd4);
        chk("full_pop_head", instr_D, 32'd2);
        step(1);

        // Redirect from a full queue.
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect_valid = 1'b0;
        chk("redir_count", 32'(count), 32'd0);
        chk("redir_valid", 32'(valid_D), 32'd0);
        chk("redir_instr", instr_D, 32'h0);
        chk("redir_pc4", pc_plus4_D, 32'h0);
        chk("redir_empty", 32'(empty), 32'd1);
        chk("redir_imem_addr", imem_addr, 32'h40);
        step(1);
        chk("redir_target_instr", instr_D, 32'd17);
        step(1);

        // Redirect during stall is ignored.
        stall_D = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        step(1);
        chk("stall_redir_count", 32'(count), 32'd2);
        chk("stall_redir_imem_addr", imem_addr, 32'h4C);
        chk("stall_redir_head", instr_D, 32'd18);
        redirect_valid = 1'b0;
        stall_D = 1'b0;
        step(1);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect_valid = 1'b0;
        chk("wrap_imem_addr", imem_addr, 32'hFFFF_FFFC);
        step(1);
        chk("wrap_pc4", pc_plus4_D, 32'h0);
        chk("wrap_next_imem_addr", imem_addr, 32'h0);
        step(1);

        // Asynchronous reset with three entries buffered.
        stall_D = 1'b1;
        step(2);
        chk("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_valid", 32'(valid_D), 32'd0);
        chk("mid_rst_instr", instr_D, 32'h0);
        chk("mid_rst_pc4", pc_plus4_D, 32'h0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_imem_addr", imem_addr, RESET_PC);

        exp_head(32'd1, 32'h04);
        exp_head(32'd2, 32'h08);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stall_D = 1'b0;
        step(1);
        chk("refill_imem_addr", imem_addr, 32'h4);
        step(2);
        stall_D = 1'b1;
        step(1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
